// File: rtl/nn_pkg.sv
// Shared types and default sizing for the accelerator load/readout sequencer.
package nn_pkg;

  // Host command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD_W = 2'd0,
    OP_LOAD_X = 2'd1,
    OP_READ_Y = 2'd2,
    OP_RSVD   = 2'd3
  } nn_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_X = 2'd2,
    ST_READ_Y = 2'd3
  } ldr_state_t;

  localparam int DEF_LAYER_SIZE  = 4;
  localparam int DEF_LAYER_DEPTH = 4;
  localparam int DEF_BIT_SIZE    = 16;
  localparam int N_WEIGHTS       = DEF_LAYER_DEPTH * DEF_LAYER_SIZE ** 2;
  localparam int N_NODES         = DEF_LAYER_SIZE;

endpackage

// File: rtl/nn_skid_fifo.sv
// Two-entry valid/ready FIFO; head_r always holds the oldest word so the
// output side is driven straight from a register.
module nn_skid_fifo #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] tail_r;
  logic [1:0]       count_r;
  logic             push_s;
  logic             pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_data  = head_r;
  assign count     = count_r;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Storage update: pops shift tail into head, pushes fill the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) head_r <= in_data;
          else                 tail_r <= in_data;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_r <= in_data;
          end else begin
            head_r <= tail_r;
            tail_r <= in_data;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/nn_stream_loader.sv
// Host-side sequencer: turns commands plus a word stream into weight/input
// memory writes, and streams the output memory back through a small FIFO.
module nn_stream_loader
  import nn_pkg::*;
#(
  parameter int LAYER_SIZE  = DEF_LAYER_SIZE,
  parameter int LAYER_DEPTH = DEF_LAYER_DEPTH,
  parameter int BIT_SIZE    = DEF_BIT_SIZE,
  parameter int RD_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [BIT_SIZE-1:0]            s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [BIT_SIZE-1:0]            m_data,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic                           weight_write_enable,
  output logic                           input_write_enable,
  output logic [$clog2(LAYER_DEPTH)-1:0] addr_layer,
  output logic [$clog2(LAYER_SIZE)-1:0]  addr_node_j,
  output logic [$clog2(LAYER_SIZE)-1:0]  addr_node_k,
  output logic [BIT_SIZE-1:0]            nn_data_in,
  input  logic [BIT_SIZE-1:0]            nn_data_out
);

  localparam int LW = $clog2(LAYER_DEPTH);
  localparam int NW = $clog2(LAYER_SIZE);
  localparam logic [NW-1:0] J_MAX  = NW'(LAYER_SIZE - 1);
  localparam logic [NW-1:0] J_ONE  = NW'(1);
  localparam logic [NW-1:0] J_ZERO = NW'(0);
  localparam logic [LW-1:0] L_MAX  = LW'(LAYER_DEPTH - 1);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [LW-1:0] L_ZERO = LW'(0);

  ldr_state_t state_r, state_s;

  logic [LW-1:0] layer_r, layer_s;
  logic [NW-1:0] j_r, j_s, k_r, k_s, rd_j_r, rd_j_s;
  logic          rd_all_r, rd_all_s;

  logic                we_w_r, we_w_s, we_x_r, we_x_s;
  logic [LW-1:0]       addr_layer_r, addr_layer_s;
  logic [NW-1:0]       addr_j_r, addr_j_s, addr_k_r, addr_k_s;
  logic [BIT_SIZE-1:0] data_r, data_s;
  logic                done_r, done_s, error_r, error_s;
  logic                issue_s, final_s;

  // Bit 0 = address on the port this cycle; bit RD_LATENCY = read data valid now.
  logic [RD_LATENCY:0] vpipe_r, lpipe_r;
  logic [7:0]          inflight_s;

  logic [1:0]          fifo_count_s;
  logic                fifo_in_ready_s, fifo_push_s, fifo_out_valid_s;
  logic [BIT_SIZE:0]   fifo_out_data_s;

  assign cmd_ready           = (state_r == ST_IDLE);
  assign busy                = (state_r != ST_IDLE);
  assign s_ready             = (state_r == ST_LOAD_W) || (state_r == ST_LOAD_X);
  assign weight_write_enable = we_w_r;
  assign input_write_enable  = we_x_r;
  assign addr_layer          = addr_layer_r;
  assign addr_node_j         = addr_j_r;
  assign addr_node_k         = addr_k_r;
  assign nn_data_in          = data_r;
  assign done                = done_r;
  assign error               = error_r;
  assign m_valid             = fifo_out_valid_s;
  assign m_last              = fifo_out_data_s[BIT_SIZE];
  assign m_data              = fifo_out_data_s[BIT_SIZE-1:0];
  assign fifo_push_s         = vpipe_r[RD_LATENCY] && fifo_in_ready_s;

  // Reads issued but not yet captured in the FIFO.
  always_comb begin
    inflight_s = 8'd0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      inflight_s = inflight_s + {7'd0, vpipe_r[i]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next state, counter advance and next values of the registered write/status outputs.
  always_comb begin
    state_s      = state_r;
    layer_s      = layer_r;
    j_s          = j_r;
    k_s          = k_r;
    rd_j_s       = rd_j_r;
    rd_all_s     = rd_all_r;
    we_w_s       = 1'b0;
    we_x_s       = 1'b0;
    addr_layer_s = addr_layer_r;
    addr_j_s     = addr_j_r;
    addr_k_s     = addr_k_r;
    data_s       = data_r;
    done_s       = 1'b0;
    error_s      = 1'b0;
    issue_s      = 1'b0;
    final_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          layer_s  = L_ZERO;
          j_s      = J_ZERO;
          k_s      = J_ZERO;
          rd_j_s   = J_ZERO;
          rd_all_s = 1'b0;
          case (nn_op_t'(cmd_op))
            OP_LOAD_W: state_s = ST_LOAD_W;
            OP_LOAD_X: state_s = ST_LOAD_X;
            OP_READ_Y: state_s = ST_READ_Y;
            default:   error_s = 1'b1;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (s_valid) begin
          we_w_s       = 1'b1;
          addr_layer_s = layer_r;
          addr_j_s     = j_r;
          addr_k_s     = k_r;
          data_s       = s_data;
          final_s      = (layer_r == L_MAX) && (j_r == J_MAX) && (k_r == J_MAX);
          if (k_r == J_MAX) begin
            k_s = J_ZERO;
            if (j_r == J_MAX) begin
              j_s     = J_ZERO;
              layer_s = (layer_r == L_MAX) ? L_ZERO : layer_r + L_ONE;
            end else begin
              j_s = j_r + J_ONE;
            end
          end else begin
            k_s = k_r + J_ONE;
          end
        end else begin
          final_s = 1'b0;
        end
      end
      ST_LOAD_X: begin
        if (s_valid) begin
          we_x_s       = 1'b1;
          addr_layer_s = L_ZERO;
          addr_j_s     = j_r;
          addr_k_s     = J_ZERO;
          data_s       = s_data;
          final_s      = (j_r == J_MAX);
          j_s          = (j_r == J_MAX) ? J_ZERO : j_r + J_ONE;
        end else begin
          final_s = 1'b0;
        end
      end
      ST_READ_Y: begin
        if (!rd_all_r && (({6'd0, fifo_count_s} + inflight_s) < 8'd2)) begin
          issue_s      = 1'b1;
          addr_layer_s = L_ZERO;
          addr_j_s     = rd_j_r;
          addr_k_s     = J_ZERO;
          rd_j_s       = (rd_j_r == J_MAX) ? J_ZERO : rd_j_r + J_ONE;
          rd_all_s     = (rd_j_r == J_MAX);
        end else begin
          issue_s = 1'b0;
        end
        if (fifo_out_valid_s && m_ready && m_last) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_READ_Y;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    // A load ends on the final word or on an early s_last; any disagreement is an error.
    if (s_valid && s_ready && (final_s || s_last)) begin
      state_s = ST_IDLE;
      done_s  = final_s && s_last;
      error_s = final_s != s_last;
    end else begin
      done_s = done_s;
    end
  end

  // Datapath registers: counters, registered outputs and the read-tracking pipes.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer_r      <= L_ZERO;
      j_r          <= J_ZERO;
      k_r          <= J_ZERO;
      rd_j_r       <= J_ZERO;
      rd_all_r     <= 1'b0;
      we_w_r       <= 1'b0;
      we_x_r       <= 1'b0;
      addr_layer_r <= L_ZERO;
      addr_j_r     <= J_ZERO;
      addr_k_r     <= J_ZERO;
      data_r       <= '0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      vpipe_r      <= '0;
      lpipe_r      <= '0;
    end else begin
      layer_r      <= layer_s;
      j_r          <= j_s;
      k_r          <= k_s;
      rd_j_r       <= rd_j_s;
      rd_all_r     <= rd_all_s;
      we_w_r       <= we_w_s;
      we_x_r       <= we_x_s;
      addr_layer_r <= addr_layer_s;
      addr_j_r     <= addr_j_s;
      addr_k_r     <= addr_k_s;
      data_r       <= data_s;
      done_r       <= done_s;
      error_r      <= error_s;
      vpipe_r      <= {vpipe_r[RD_LATENCY-1:0], issue_s};
      lpipe_r      <= {lpipe_r[RD_LATENCY-1:0], issue_s && (rd_j_r == J_MAX)};
    end
  end

  nn_skid_fifo #(.WIDTH(BIT_SIZE + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fifo_push_s),
    .in_ready  (fifo_in_ready_s),
    .in_data   ({lpipe_r[RD_LATENCY], nn_data_out}),
    .out_valid (fifo_out_valid_s),
    .out_ready (m_ready),
    .out_data  (fifo_out_data_s),
    .count     (fifo_count_s)
  );

endmodule
